word_tokenizer: RTL and testbench

- Upstream stage of the begin/end nesting checker in the splitter path.
- Consumes a raw 8-bit ASCII character stream and splits it into space-delimited words.
- Case-insensitively classifies each word as BEGIN, END or OTHER and emits one registered token per completed word, with word length and running word count.
- The checker then works on clean tokens instead of re-parsing characters.

---
 rtl/word_tokenizer.sv | 143 ++++++++++++++
 tb/tb_word_tokenizer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/word_tokenizer.sv
// Splits an ASCII byte stream into space-delimited words and emits one registered
// BEGIN/END/OTHER token per word. Define TOKENIZER_EXT_DELIM_EN to also treat TAB/LF/CR as delimiters.
module word_tokenizer #(
   parameter int LEN_W = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_char,
   input  logic             eos,
   output logic             tok_valid,
   output logic [1:0]       tok_type,
   output logic [LEN_W-1:0] tok_len,
   output logic [CNT_W-1:0] word_cnt,
   output logic             in_word,
   output logic [3:0]       dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
   } state_t;

   localparam logic [1:0] T_OTHER = 2'b00;
   localparam logic [1:0] T_BEGIN = 2'b01;
   localparam logic [1:0] T_END   = 2'b10;
   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             tok_valid_q, tok_valid_d;
   logic [1:0]       tok_type_q, tok_type_d;
   logic [LEN_W-1:0] tok_len_q, tok_len_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

   logic             is_delim;
   state_t           char_state, term_state;
   logic [LEN_W-1:0] char_len, term_len;
   logic             term;

   // lc is the lower-case letter; the upper-case form is exactly 0x20 below it.
   function automatic logic is_ci(input logic [7:0] c, input logic [7:0] lc);
      return (c == lc) || (c == (lc - 8'h20));
   endfunction

   function automatic state_t next_state(input state_t s, input logic [7:0] c);
      state_t n;
      n = S_OTHER;
      case (s)
         S_IDLE: begin
            if (is_ci(c, "b"))      n = S_B;
            else if (is_ci(c, "e")) n = S_E;
         end
         S_B:    if (is_ci(c, "e")) n = S_BE;
         S_BE:   if (is_ci(c, "g")) n = S_BEG;
         S_BEG:  if (is_ci(c, "i")) n = S_BEGI;
         S_BEGI: if (is_ci(c, "n")) n = S_BEGIN;
         S_E:    if (is_ci(c, "n")) n = S_EN;
         S_EN:   if (is_ci(c, "d")) n = S_END;
         default: n = S_OTHER;
      endcase
      return n;
   endfunction

   function automatic logic [1:0] type_of(input state_t s);
      if (s == S_BEGIN)    return T_BEGIN;
      else if (s == S_END) return T_END;
      else                 return T_OTHER;
   endfunction

`ifdef TOKENIZER_EXT_DELIM_EN
   assign is_delim = (in_char == 8'h20) || (in_char == 8'h09) ||
                     (in_char == 8'h0A) || (in_char == 8'h0D);
`else
   assign is_delim = (in_char == 8'h20);
`endif

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      tok_valid_d = 1'b0;
      tok_type_d  = tok_type_q;
      tok_len_d   = tok_len_q;
      word_cnt_d  = word_cnt_q;
      char_state  = next_state(state_q, in_char);
      char_len    = (state_q == S_IDLE) ? LEN_ONE :
                    (len_q == LEN_MAX) ? len_q : len_q + LEN_ONE;
      term        = 1'b0;
      term_state  = state_q;
      term_len    = len_q;

      if (in_valid && is_delim) begin
         term = (state_q != S_IDLE);
      end else if (in_valid) begin
         state_d = char_state;
         len_d   = char_len;
         // eos with a word character: the character joins the word, then it closes
         if (eos) begin
            term       = 1'b1;
            term_state = char_state;
            term_len   = char_len;
         end
      end else if (eos) begin
         term = (state_q != S_IDLE);
      end

      if (term) begin
         state_d     = S_IDLE;
         len_d       = '0;
         tok_valid_d = 1'b1;
         tok_type_d  = type_of(term_state);
         tok_len_d   = term_len;
         word_cnt_d  = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         tok_valid_q <= 1'b0;
         tok_type_q  <= T_OTHER;
         tok_len_q   <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         tok_valid_q <= tok_valid_d;
         tok_type_q  <= tok_type_d;
         tok_len_q   <= tok_len_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign tok_valid = tok_valid_q;
   assign tok_type  = tok_type_q;
   assign tok_len   = tok_len_q;
   assign word_cnt  = word_cnt_q;
   assign in_word   = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_word_tokenizer.sv
// Self-checking bench for word_tokenizer: a vector table, hand-written corner sequences
// and a randomised stretch checked against a word-buffer reference model.
module tb_word_tokenizer;

   localparam int LEN_W = 8;
   localparam int CNT_W = 16;
   localparam int W     = 2 + LEN_W;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [7:0]       in_char;
   logic             eos;
   logic             tok_valid;
   logic [1:0]       tok_type;
   logic [LEN_W-1:0] tok_len;
   logic [CNT_W-1:0] word_cnt;
   logic             in_word;
   logic [3:0]       dbg_state;

   word_tokenizer #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char), .eos(eos),
      .tok_valid(tok_valid), .tok_type(tok_type), .tok_len(tok_len),
      .word_cnt(word_cnt), .in_word(in_word), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             v;
      logic [7:0]       c;
      logic             e;
      logic             tv;
      logic [1:0]       tt;
      logic [LEN_W-1:0] tl;
      logic             iw;
   } vec_t;

   vec_t             tbl[$];
   logic [W-1:0]     exp_q[$];
   logic [CNT_W-1:0] exp_cnt;
   logic [1:0]       last_t;
   logic [LEN_W-1:0] last_l;
   int               n_vec = 0;
   int               n_err = 0;

   // reference model state
   logic             m_open;
   int               m_len;
   logic [7:0]       m_buf[0:4];

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] c, input logic e, input logic tv,
                      input logic [1:0] tt, input logic [LEN_W-1:0] tl, input logic iw);
      vec_t r;
      r.v = v; r.c = c; r.e = e; r.tv = tv; r.tt = tt; r.tl = tl; r.iw = iw;
      tbl.push_back(r);
   endtask

   task automatic add_chars(input string s);
      for (int i = 0; i < s.len(); i++) add(1'b1, s[i], 1'b0, 1'b0, 2'b00, '0, 1'b1);
   endtask

   // drive one cycle, push the expected token, then check after the edge
   task automatic step(input logic v, input logic [7:0] c, input logic e, input logic push,
                       input logic [1:0] t, input logic [LEN_W-1:0] l, input logic iw);
      logic [W-1:0] x;
      @(negedge clk);
      in_valid = v; in_char = c; eos = e;
      if (push) begin
         exp_q.push_back({t, l});
         exp_cnt = exp_cnt + 1'b1;
      end
      @(posedge clk);
      #1;
      n_vec++;
      cmp("tok_valid", 32'(tok_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         last_t = x[W-1 -: 2];
         last_l = x[LEN_W-1:0];
      end
      cmp("tok_type", 32'(tok_type), 32'(last_t));
      cmp("tok_len", 32'(tok_len), 32'(last_l));
      cmp("word_cnt", 32'(word_cnt), 32'(exp_cnt));
      cmp("in_word", 32'(in_word), 32'(iw));
   endtask

   function automatic logic m_delim(input logic [7:0] c);
`ifdef TOKENIZER_EXT_DELIM_EN
      return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
`else
      return c == 8'h20;
`endif
   endfunction

   function automatic logic [1:0] m_class();
      if (m_len == 5 && m_buf[0] == "b" && m_buf[1] == "e" && m_buf[2] == "g" &&
          m_buf[3] == "i" && m_buf[4] == "n") return 2'b01;
      if (m_len == 3 && m_buf[0] == "e" && m_buf[1] == "n" && m_buf[2] == "d") return 2'b10;
      return 2'b00;
   endfunction

   // model one input cycle then apply it through step()
   task automatic model_step(input logic v, input logic [7:0] c, input logic e);
      logic             push = 1'b0;
      logic [1:0]       t = 2'b00;
      logic [LEN_W-1:0] l = '0;
      logic [7:0]       lc;
      if (v && m_delim(c)) begin
         if (m_open) begin push = 1'b1; m_open = 1'b0; end
      end else if (v) begin
         if (!m_open) begin m_open = 1'b1; m_len = 0; end
         lc = (c >= "A" && c <= "Z") ? c + 8'h20 : c;
         if (m_len < 5) m_buf[m_len] = lc;
         m_len++;
         if (e) begin push = 1'b1; m_open = 1'b0; end
      end else if (e && m_open) begin
         push = 1'b1; m_open = 1'b0;
      end
      if (push) begin
         t = m_class();
         l = (m_len > 255) ? 8'd255 : 8'(m_len);
      end
      step(v, c, e, push, t, l, m_open);
   endtask

   initial begin
      string pool;
      pool = "bBeEgGiInNdDx  ";
      reset = 1'b1; in_valid = 1'b0; in_char = 8'h00; eos = 1'b0;
      exp_cnt = '0; last_t = 2'b00; last_l = '0;
      m_open = 1'b0; m_len = 0;

      // BeGiN, "end  beginx e ", eos with a char, eos in idle, eos with a space, eos alone
      add_chars("BeGiN"); add(1, 8'h20, 0, 1, 2'b01, 5, 0);
      add_chars("end");   add(1, 8'h20, 0, 1, 2'b10, 3, 0);
      add(1, 8'h20, 0, 0, 2'b00, 0, 0);
      add_chars("beginx"); add(1, 8'h20, 0, 1, 2'b00, 6, 0);
      add_chars("e");     add(1, 8'h20, 0, 1, 2'b00, 1, 0);
      add_chars("en");    add(1, "d", 1, 1, 2'b10, 3, 0);
      add(0, 8'h00, 0, 0, 2'b00, 0, 0);
      add(0, 8'h00, 1, 0, 2'b00, 0, 0);
      add(1, 8'h20, 1, 0, 2'b00, 0, 0);
      add_chars("ab");    add(1, 8'h20, 1, 1, 2'b00, 2, 0);
      add_chars("END");   add(0, "x", 1, 1, 2'b10, 3, 0);
      add_chars("Bg");    add(1, 8'h20, 0, 1, 2'b00, 2, 0);
      add_chars("a");     add(1, 8'h20, 0, 1, 2'b00, 1, 0);
      add_chars("b");     add(1, 8'h20, 0, 1, 2'b00, 1, 0);

      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      cmp("rst_tok_valid", 32'(tok_valid), 0);
      cmp("rst_tok_type", 32'(tok_type), 0);
      cmp("rst_tok_len", 32'(tok_len), 0);
      cmp("rst_word_cnt", 32'(word_cnt), 0);
      cmp("rst_in_word", 32'(in_word), 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) step(tbl[i].v, tbl[i].c, tbl[i].e, tbl[i].tv, tbl[i].tt, tbl[i].tl, tbl[i].iw);

      // extended delimiters
      begin
         string s;
         s = "end\tbegin\n";
`ifdef TOKENIZER_EXT_DELIM_EN
         for (int i = 0; i < s.len(); i++) begin
            if (i == 3)      step(1, s[i], 0, 1, 2'b10, 3, 0);
            else if (i == 9) step(1, s[i], 0, 1, 2'b01, 5, 0);
            else             step(1, s[i], 0, 0, 2'b00, 0, 1);
         end
`else
         for (int i = 0; i < s.len(); i++) step(1, s[i], 0, 0, 2'b00, 0, 1);
         step(1, 8'h20, 0, 1, 2'b00, 10, 0);
`endif
      end

      // in_valid toggling: idle cycles carry junk that must be ignored
      begin
         string s;
         s = "begin";
         for (int i = 0; i < s.len(); i++) begin
            step(1, s[i], 0, 0, 2'b00, 0, 1);
            step(0, 8'($urandom_range(0, 255)), 0, 0, 2'b00, 0, 1);
         end
         step(1, 8'h20, 0, 1, 2'b01, 5, 0);
      end

      // randomised stream against the reference model
      for (int i = 0; i < 300; i++) begin
         logic [7:0] c;
         c = pool[$urandom_range(0, pool.len() - 1)];
         model_step($urandom_range(0, 7) != 0, c, $urandom_range(0, 9) == 0);
      end
      if (m_open) model_step(1'b1, 8'h20, 1'b0);

      // length saturation
      for (int i = 0; i < 300; i++) step(1, "x", 0, 0, 2'b00, 0, 1);
      step(1, 8'h20, 0, 1, 2'b00, 8'd255, 0);

      // reset mid-word discards the partial word
      step(1, "b", 0, 0, 2'b00, 0, 1);
      step(1, "e", 0, 0, 2'b00, 0, 1);
      step(1, "g", 0, 0, 2'b00, 0, 1);
      step(1, "i", 0, 0, 2'b00, 0, 1);
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0;
      #1;
      n_vec++;
      cmp("mid_rst_tok_valid", 32'(tok_valid), 0);
      cmp("mid_rst_tok_type", 32'(tok_type), 0);
      cmp("mid_rst_tok_len", 32'(tok_len), 0);
      cmp("mid_rst_word_cnt", 32'(word_cnt), 0);
      cmp("mid_rst_in_word", 32'(in_word), 0);
      exp_cnt = '0; last_t = 2'b00; last_l = '0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1, 8'h20, 0, 0, 2'b00, 0, 0);
      step(1, "n", 0, 0, 2'b00, 0, 1);
      step(1, 8'h20, 0, 1, 2'b00, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
